// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch-PC generator with redirect mux, credit-limited
// memory request port with an in-order tag FIFO, and a show-ahead prefetch queue to ID.
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic [1:0]             redirect_sel,
    input  logic [ADDR_W-1:0]      ta,
    input  logic [ADDR_W-1:0]      alu_out,
    output logic                   imem_req_valid,
    output logic [ADDR_W-1:0]      imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [DATA_W-1:0]      imem_rsp_data,
    output logic                   id_valid,
    output logic [DATA_W-1:0]      id_instr,
    output logic [ADDR_W-1:0]      id_pc,
    input  logic                   id_ready,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   spurious_rsp
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // valid never depends on ready; imem responses carry no ready and arrive in request order.

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]     out_q, out_d;
    logic [OW-1:0]     drop_q, drop_d;
    logic              spur_q, spur_d;
    logic [TW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [ADDR_W-1:0] tag_q    [MAX_OUT];
    logic [ADDR_W-1:0] q_pc_q   [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];

    logic redirect, req_valid, acc, rsp_take, rsp_spur, q_push, q_pop;

    always_comb begin
        redirect  = redirect_sel != 2'b00;
        req_valid = !R && !redirect
                    && (32'(count_q) + 32'(out_q) < 32'(DEPTH))
                    && (32'(out_q) < 32'(MAX_OUT));
        acc       = req_valid && imem_req_ready;
        rsp_take  = imem_rsp_valid && (out_q != '0);
        rsp_spur  = imem_rsp_valid && (out_q == '0);
        q_push    = !R && !redirect && rsp_take && (drop_q == '0);
        q_pop     = !redirect && (count_q != '0) && id_ready;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_d      = out_q;
        drop_d     = drop_q;
        spur_d     = spur_q | rsp_spur;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;

        if (acc)
            tag_wr_d = (tag_wr_q == TW'(MAX_OUT - 1)) ? '0 : tag_wr_q + TW'(1);
        if (rsp_take)
            tag_rd_d = (tag_rd_q == TW'(MAX_OUT - 1)) ? '0 : tag_rd_q + TW'(1);

        if (acc && !rsp_take)
            out_d = out_q + OW'(1);
        else if (!acc && rsp_take)
            out_d = out_q - OW'(1);

        if (redirect) begin
            unique case (redirect_sel)
                2'b01:   fetch_pc_d = ta;
                2'b10:   fetch_pc_d = alu_out;
                default: fetch_pc_d = RESET_PC;
            endcase
            // Every response still in flight belongs to the squashed path.
            drop_d   = rsp_take ? out_q - OW'(1) : out_q;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (acc)
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            if (rsp_take && (drop_q != '0))
                drop_d = drop_q - OW'(1);
            if (q_push)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (q_pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (q_push && !q_pop)
                count_d = count_q + CW'(1);
            else if (!q_push && q_pop)
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            spur_q     <= 1'b0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            spur_q     <= spur_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc)
            tag_q[tag_wr_q] <= fetch_pc_q;
        if (q_push) begin
            q_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
            q_data_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    always_comb begin
        imem_req_valid = req_valid;
        imem_req_addr  = R ? RESET_PC : fetch_pc_q;
        id_valid       = !R && (count_q != '0);
        id_instr       = q_data_q[rd_ptr_q];
        id_pc          = q_pc_q[rd_ptr_q];
        q_count        = R ? '0 : count_q;
        spurious_rsp   = spur_q;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch front end.
module tb_if_fetch_queue;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic [1:0]  redirect_sel = 2'b00;
    logic [31:0] ta = '0, alu_out = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    logic        id_ready = 1'b0;
    logic [2:0]  q_count;
    logic        spurious_rsp;

    if_fetch_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .R(R), .redirect_sel(redirect_sel), .ta(ta), .alu_out(alu_out),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_ready(id_ready), .q_count(q_count), .spurious_rsp(spurious_rsp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int mem_lat_min = 1, mem_lat_max = 1;

    // memory model: accepted addresses with the cycle their response is due
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    // reference model: fetch pc, in-flight request pcs (dead = squashed), ID queue
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] if_pc[$];
    bit          if_dead[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_data_q[$];
    bit          m_spur = 1'b0;

    logic        exp_req_valid, exp_id_valid;
    logic [31:0] exp_addr;
    logic [2:0]  exp_count;
    logic        dut_acc;
    logic [31:0] dut_addr;

    task automatic settle();
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr_q[0] ^ MAGIC;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_req_valid = !R && redirect_sel == 2'b00
                        && (exp_pc_q.size() + if_pc.size()) < DEPTH && if_pc.size() < MAX_OUT;
        exp_addr      = R ? RESET_PC : m_pc;
        exp_id_valid  = !R && exp_pc_q.size() != 0;
        exp_count     = R ? 3'd0 : 3'(exp_pc_q.size());
        dut_acc       = imem_req_valid && imem_req_ready;
        dut_addr      = imem_req_addr;
    endtask

    task automatic tick();
        bit          took;
        logic [31:0] p;
        @(posedge clk);
        if (imem_rsp_valid) begin
            mem_addr_q.delete(0);
            mem_due_q.delete(0);
        end
        if (dut_acc) begin
            mem_addr_q.push_back(dut_addr);
            mem_due_q.push_back(cyc + $urandom_range(mem_lat_min, mem_lat_max));
        end
        if (R) begin
            m_pc = RESET_PC;
            if_pc.delete(); if_dead.delete();
            exp_pc_q.delete(); exp_data_q.delete();
            m_spur = 1'b0;
        end else begin
            took = 1'b0;
            p    = '0;
            if (imem_rsp_valid) begin
                if (if_pc.size() == 0) m_spur = 1'b1;
                else begin
                    p    = if_pc.pop_front();
                    took = !if_dead.pop_front();
                end
            end
            if (redirect_sel != 2'b00) begin
                foreach (if_dead[i]) if_dead[i] = 1'b1;
                exp_pc_q.delete(); exp_data_q.delete();
                m_pc = (redirect_sel == 2'b01) ? ta : (redirect_sel == 2'b10) ? alu_out : RESET_PC;
            end else begin
                if (id_ready && exp_pc_q.size() > 0) begin
                    exp_pc_q.delete(0); exp_data_q.delete(0);
                end
                if (took) begin
                    exp_pc_q.push_back(p); exp_data_q.push_back(imem_rsp_data);
                end
                if (exp_req_valid && imem_req_ready) begin
                    if_pc.push_back(m_pc); if_dead.push_back(1'b0);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        R = 1'b1; redirect_sel = 2'b00; imem_req_ready = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 20 && (i < 2 || mem_addr_q.size() > 0); i++) begin
            settle(); tick();
        end
        R = 1'b0;
    endtask

    task automatic test_reset();
        R = 1'b1; redirect_sel = 2'b01; ta = 32'h55; imem_req_ready = 1'b1; id_ready = 1'b1;
        settle();
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || id_valid !== 1'b0 || q_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_during: req_valid=%b addr=%h id_valid=%b q_count=%0d, need 0/%h/0/0",
                     imem_req_valid, imem_req_addr, id_valid, q_count, RESET_PC);
        end
        tick(); settle(); tick();
        R = 1'b0; redirect_sel = 2'b00;
        settle();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || id_valid !== 1'b0 || spurious_rsp !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after: req_valid=%b addr=%h id_valid=%b spur=%b, need 1/%h/0/0",
                     imem_req_valid, imem_req_addr, id_valid, spurious_rsp, RESET_PC);
        end
        tick();
    endtask

    task automatic test_free_flow();
        int first_acc, first_vld, got;
        logic [31:0] want;
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        id_ready = 1'b1; imem_req_ready = 1'b1;
        first_acc = -1; first_vld = -1; got = 0; want = 32'h0;
        for (int c = 0; c < 20; c++) begin
            settle();
            if (first_acc < 0 && exp_req_valid) first_acc = c;
            if (id_valid === 1'b1) begin
                if (first_vld < 0) first_vld = c;
                n_checks++;
                if (id_pc !== want || id_instr !== (want ^ MAGIC)) begin
                    n_err++;
                    $display("FAIL free_flow_item: pc=%h instr=%h, need pc=%h instr=%h",
                             id_pc, id_instr, want, want ^ MAGIC);
                end
                want += 32'd4; got++;
            end
            tick();
        end
        n_checks++;
        if (first_vld - first_acc != 2) begin
            n_err++;
            $display("FAIL free_flow_latency: first valid %0d cycles after acceptance, need 2", first_vld - first_acc);
        end
        n_checks++;
        if (got != 18) begin
            n_err++;
            $display("FAIL free_flow_count: %0d instructions delivered, need 18", got);
        end
    endtask

    task automatic test_stall();
        int got;
        logic [31:0] want;
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        id_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (12) begin settle(); tick(); end
        settle();
        n_checks++;
        if (q_count !== 3'd4 || imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
            n_err++;
            $display("FAIL stall_full: q_count=%0d req_valid=%b id_valid=%b id_pc=%h, need 4/0/1/0",
                     q_count, imem_req_valid, id_valid, id_pc);
        end
        tick();
        id_ready = 1'b1; got = 0; want = 32'h0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            settle();
            if (id_valid === 1'b1) begin
                n_checks++;
                if (id_pc !== want || id_instr !== (want ^ MAGIC)) begin
                    n_err++;
                    $display("FAIL stall_release: pc=%h instr=%h, need pc=%h", id_pc, id_instr, want);
                end
                want += 32'd4; got++;
            end
            tick();
        end
        n_checks++;
        if (got != 5) begin
            n_err++;
            $display("FAIL stall_release_count: %0d delivered within budget, need 5", got);
        end
    endtask

    task automatic test_redirect_inflight();
        bit seen;
        do_reset();
        mem_lat_min = 3; mem_lat_max = 3;
        id_ready = 1'b1; imem_req_ready = 1'b1;
        settle(); tick(); settle(); tick();
        settle();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_inflight_credit: req_valid=%b with two outstanding, need 0", imem_req_valid);
        end
        redirect_sel = 2'b01; ta = 32'h100;
        settle(); tick();
        redirect_sel = 2'b00;
        settle();
        n_checks++;
        if (q_count !== 3'd0 || id_valid !== 1'b0 || imem_req_addr !== 32'h100) begin
            n_err++;
            $display("FAIL redir_inflight_after: q_count=%0d id_valid=%b addr=%h, need 0/0/100",
                     q_count, id_valid, imem_req_addr);
        end
        tick();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            settle();
            if (id_valid === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (id_pc !== 32'h100 || id_instr !== (32'h100 ^ MAGIC)) begin
                    n_err++;
                    $display("FAIL redir_inflight_first: pc=%h instr=%h, need pc=100", id_pc, id_instr);
                end
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_err++;
            $display("FAIL redir_inflight_timeout: no instruction after redirect, need pc=100");
        end
    endtask

    task automatic test_redirect_rsp();
        bit seen;
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        id_ready = 1'b1; imem_req_ready = 1'b1;
        repeat (3) begin settle(); tick(); end
        redirect_sel = 2'b10; alu_out = 32'h40;
        settle(); tick();
        redirect_sel = 2'b00;
        settle();
        n_checks++;
        if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_req_addr !== 32'h40) begin
            n_err++;
            $display("FAIL redir_rsp_after: id_valid=%b q_count=%0d addr=%h, need 0/0/40",
                     id_valid, q_count, imem_req_addr);
        end
        tick();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            settle();
            if (id_valid === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (id_pc !== 32'h40) begin
                    n_err++;
                    $display("FAIL redir_rsp_first: pc=%h, need 40", id_pc);
                end
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_err++;
            $display("FAIL redir_rsp_timeout: no instruction after redirect, need pc=40");
        end
    endtask

    task automatic test_trap_wrap();
        logic [31:0] want [3];
        int got;
        bit seen;
        do_reset();
        mem_lat_min = 1; mem_lat_max = 1;
        id_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_sel = 2'b01; ta = 32'hFFFF_FFF8;
        settle(); tick();
        redirect_sel = 2'b00;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (c < 3) begin
                n_checks++;
                if (imem_req_addr !== want[c] || imem_req_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL wrap_addr%0d: addr=%h valid=%b, need %h/1", c, imem_req_addr, imem_req_valid, want[c]);
                end
            end
            if (id_valid === 1'b1 && got < 3) begin
                n_checks++;
                if (id_pc !== want[got]) begin
                    n_err++;
                    $display("FAIL wrap_id%0d: pc=%h, need %h", got, id_pc, want[got]);
                end
                got++;
            end
            tick();
        end
        n_checks++;
        if (got != 3) begin
            n_err++;
            $display("FAIL wrap_count: %0d delivered, need 3", got);
        end
        redirect_sel = 2'b01; ta = 32'h200;
        settle(); tick();
        redirect_sel = 2'b00;
        repeat (2) begin settle(); tick(); end
        redirect_sel = 2'b11;
        settle(); tick();
        redirect_sel = 2'b00;
        settle();
        n_checks++;
        if (imem_req_addr !== RESET_PC || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL trap_addr: addr=%h id_valid=%b, need %h/0", imem_req_addr, id_valid, RESET_PC);
        end
        tick();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            settle();
            if (id_valid === 1'b1) begin
                seen = 1'b1;
                n_checks++;
                if (id_pc !== RESET_PC) begin
                    n_err++;
                    $display("FAIL trap_first: pc=%h, need %h", id_pc, RESET_PC);
                end
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_err++;
            $display("FAIL trap_timeout: no instruction after trap redirect");
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat_min = 3; mem_lat_max = 3;
        id_ready = 1'b0; imem_req_ready = 1'b1;
        for (int c = 0; c < 40 && !(exp_pc_q.size() >= 2 && if_pc.size() == 2); c++) begin
            settle(); tick();
        end
        R = 1'b1; imem_req_ready = 1'b0;
        settle();
        n_checks++;
        if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_req_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL reset_mid_during: id_valid=%b q_count=%0d addr=%h, need 0/0/%h",
                     id_valid, q_count, imem_req_addr, RESET_PC);
        end
        tick();
        R = 1'b0;
        settle();
        n_checks++;
        if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_req_addr !== RESET_PC || spurious_rsp !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_after: id_valid=%b q_count=%0d addr=%h spur=%b, need 0/0/%h/0",
                     id_valid, q_count, imem_req_addr, spurious_rsp, RESET_PC);
        end
        tick();
        repeat (6) begin settle(); tick(); end
        settle();
        n_checks++;
        if (spurious_rsp !== 1'b1 || q_count !== 3'd0 || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_stale: spur=%b q_count=%0d id_valid=%b, need 1/0/0",
                     spurious_rsp, q_count, id_valid);
        end
        tick();
    endtask

    task automatic test_random_traffic();
        do_reset();
        mem_lat_min = 1; mem_lat_max = 3;
        for (int c = 0; c < 600; c++) begin
            redirect_sel   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ta             = $urandom & 32'hFFFF_FFFC;
            alu_out        = $urandom & 32'hFFFF_FFFC;
            id_ready       = $urandom_range(0, 3) != 0;
            imem_req_ready = $urandom_range(0, 3) != 0;
            settle();
            n_checks++;
            if (imem_req_valid !== exp_req_valid || imem_req_addr !== exp_addr || id_valid !== exp_id_valid
                || q_count !== exp_count || spurious_rsp !== m_spur) begin
                n_err++;
                $display("FAIL rand_ctrl c%0d: req_valid=%b addr=%h id_valid=%b q_count=%0d spur=%b, need %b/%h/%b/%0d/%b",
                         c, imem_req_valid, imem_req_addr, id_valid, q_count, spurious_rsp,
                         exp_req_valid, exp_addr, exp_id_valid, exp_count, m_spur);
            end
            if (exp_id_valid) begin
                n_checks++;
                if (id_pc !== exp_pc_q[0] || id_instr !== exp_data_q[0]) begin
                    n_err++;
                    $display("FAIL rand_head c%0d: pc=%h instr=%h, need pc=%h instr=%h",
                             c, id_pc, id_instr, exp_pc_q[0], exp_data_q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_free_flow();
        test_stall();
        test_redirect_inflight();
        test_redirect_rsp();
        test_trap_wrap();
        test_reset_mid();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parameterised instruction-fetch front end for the pipeline. It replaces the single-shot fetch path (PC, next-PC mux and one IF/ID latch) with three parts: a fetch-PC generator with a target-select redirect mux, a memory request/response port with a bounded number of outstanding requests, and a DEPTH-entry prefetch queue that feeds the ID stage through a valid/ready handshake. Redirects from later stages squash the queue and all in-flight responses, and fetch restarts at the selected target.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
DEPTH, 4, prefetch queue entries; power of two, >= 2
MAX_OUT, 2, maximum outstanding memory requests, >= 1
RESET_PC, 0, fetch address after reset and for trap redirect (sel = 11)

Ports:
clk  in  1  clock, rising edge
R  in  1  synchronous active-high reset
redirect_sel  in  2  00 sequential, 01 branch target ta, 10 alu_out, 11 RESET_PC
ta  in  ADDR_W  branch/call target address
alu_out  in  ADDR_W  computed jump target (jmpl)
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  ADDR_W  fetch address
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  instruction returned; in-order, >= 1 cycle after acceptance
imem_rsp_data  in  DATA_W  returned instruction
id_valid  out  1  queue head valid
id_instr  out  DATA_W  queue head instruction
id_pc  out  ADDR_W  PC of queue head
id_ready  in  1  ID stage consumes head (low = stall)
q_count  out  clog2(DEPTH)+1  occupied queue entries
spurious_rsp  out  1  sticky; set when a response arrives with nothing outstanding

Behaviour:
- Reset (R=1 at posedge): fetch_pc <= RESET_PC; queue empty; outstanding <= 0; drop_cnt <= 0; spurious_rsp <= 0. During and after the reset cycle: id_valid=0, q_count=0, imem_req_addr=RESET_PC. R overrides every other input, including a redirect in the same cycle.
- imem_req_addr = fetch_pc, driven combinationally.
- imem_req_valid = !R && redirect_sel==00 && (q_count + outstanding) < DEPTH && outstanding < MAX_OUT. The credit check guarantees the queue never overflows.
- Request acceptance is imem_req_valid && imem_req_ready. On acceptance: fetch_pc <= fetch_pc + 4 (modulo 2^ADDR_W, wraps silently) and outstanding increments. The PC of each request is pushed into a MAX_OUT-deep tag FIFO.
- Response: the oldest tag PC is popped.
  - If drop_cnt > 0: drop_cnt decrements and the response is discarded.
  - Otherwise {tag PC, imem_rsp_data} is pushed into the queue.
  - In both cases outstanding decrements.
  - If outstanding == 0 (counting any acceptance in the same cycle as not yet outstanding): the response is ignored, spurious_rsp <= 1, and no counter changes.
- Queue is show-ahead. id_valid = q_count != 0, and id_instr/id_pc present the head with zero added latency. Pop occurs when id_valid && id_ready. Push and pop in the same cycle leave q_count unchanged, including at full.
- Minimum latency: a request accepted at cycle t with its response at t+1 is visible on id_* at cycle t+2 (registered into the queue at the t+1 edge).
- Redirect (redirect_sel != 00, evaluated at the posedge):
  - fetch_pc <= ta, alu_out, or RESET_PC according to sel.
  - Queue is emptied; any pop that cycle is ignored.
  - drop_cnt <= outstanding minus 1 if a response arrives this cycle (that response is itself discarded).
  - No request is issued during the redirect cycle.
  - A redirect while drop_cnt > 0 recomputes drop_cnt from the current outstanding count.
- Back-to-back redirects: the last one wins. Fetching starts the cycle after the last redirect.
- outstanding and drop_cnt never exceed MAX_OUT and never underflow.

Test Plan:
- Free flow: R for 2 cycles, 1-cycle memory returning data = address ^ 32'hA5A5_0000, id_ready=1 -> id_pc sequence 0,4,8,C…; first id_valid two cycles after the first acceptance; id_instr matches the address.
- Stall: DEPTH=4, id_ready=0 for 12 cycles -> q_count saturates at 4, imem_req_valid=0, queue holds pc 0..C. On release, pc 0,4,8,C then 10 emerge with no loss or duplication.
- Redirect with in-flight: latency 3, MAX_OUT=2, two requests outstanding, redirect_sel=01, ta=0x100 -> both late responses discarded, q_count=0, next imem_req_addr=0x100, next id_pc=0x100.
- Redirect coinciding with a response: redirect_sel=10, alu_out=0x40, imem_rsp_valid=1 in the same cycle -> response dropped, id_valid=0 next cycle, subsequent id_pc=0x40.
- Trap redirect and wrap: fetch_pc=0xFFFF_FFFC, then sel=11 -> fetch resumes at RESET_PC. Separately, without redirect, the address after 0xFFFF_FFFC is 0x0.
- Reset mid-operation with a full queue and 2 outstanding -> next cycle id_valid=0, q_count=0, imem_req_addr=RESET_PC. A stale response afterwards sets spurious_rsp=1 and the queue stays empty.
